// File: rtl/llc_snoop_responder_if.sv
// Snoop-side bus bundle for the LLC snoop responder: snooped ops, result, DRAM writeback,
// L1 messages and the local fill port.
interface llc_snoop_responder_if #(
  parameter int ADDR_W = 32
);
  logic              bus_valid;
  logic              bus_ready;
  logic [2:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              snoop_valid;
  logic [1:0]        snoop_result;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic              l1_msg_valid;
  logic [2:0]        l1_msg;
  logic [ADDR_W-1:0] l1_msg_addr;
  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic [1:0]        fill_state;

  modport master (
    output bus_valid, bus_op, bus_addr, wb_ready, fill_valid, fill_addr, fill_state,
    input  bus_ready, snoop_valid, snoop_result, wb_valid, wb_addr,
           l1_msg_valid, l1_msg, l1_msg_addr, fill_ready
  );

  modport slave (
    input  bus_valid, bus_op, bus_addr, wb_ready, fill_valid, fill_addr, fill_state,
    output bus_ready, snoop_valid, snoop_result, wb_valid, wb_addr,
           l1_msg_valid, l1_msg, l1_msg_addr, fill_ready
  );
endinterface

// File: rtl/llc_snoop_responder.sv
// Direct-mapped MESI snoop responder: answers snooped bus ops, pulls dirty data from L1 and
// writes it back, and invalidates L1 copies. States: IDLE accept | LOOKUP tag read |
// RESPOND result | GETL1 fetch from L1 | WBACK DRAM writeback | UPDATE MESI write.
module llc_snoop_responder #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  llc_snoop_responder_if.slave  bus,
  output logic [15:0]           snoop_count,
  output logic [15:0]           hitm_count
);
  localparam int TAG_W  = ADDR_W - OFFSET_W - INDEX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [1:0] RES_NOHIT = 2'd0;
  localparam logic [1:0] RES_HIT   = 2'd1;
  localparam logic [1:0] RES_HITM  = 2'd2;

  localparam logic [2:0] MSG_GETLINE = 3'd1;
  localparam logic [2:0] MSG_INVLINE = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESPOND, S_GETL1, S_WBACK, S_UPDATE
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_arr [LINES];
  logic [1:0]        mesi_arr [LINES];
  logic [2:0]        op_q;
  logic [LINE_W-1:0] line_q;
  logic              match_q;
  logic [1:0]        mesi_q;

  logic [INDEX_W-1:0] idx_q, fill_idx, bus_idx_unused_free;
  logic [TAG_W-1:0]   tag_q, fill_tag;
  logic [ADDR_W-1:0]  line_addr;
  logic               op_known;
  logic [1:0]         result;
  logic [1:0]         mesi_upd;
  logic               accept;
  logic               fill_go;
  logic               unused_bits;

  assign idx_q     = line_q[INDEX_W-1:0];
  assign tag_q     = line_q[LINE_W-1:INDEX_W];
  assign line_addr = {line_q, {OFFSET_W{1'b0}}};
  assign fill_idx  = bus.fill_addr[OFFSET_W +: INDEX_W];
  assign fill_tag  = bus.fill_addr[ADDR_W-1 -: TAG_W];
  assign bus_idx_unused_free = '0;
  assign unused_bits = ^{bus.bus_addr[OFFSET_W-1:0], bus.fill_addr[OFFSET_W-1:0],
                         bus_idx_unused_free};

  assign bus.bus_ready  = (state == S_IDLE);
  assign bus.fill_ready = (state == S_IDLE) && !bus.bus_valid;
  assign accept  = (state == S_IDLE) && bus.bus_valid;
  assign fill_go = bus.fill_valid && bus.fill_ready;

  // Undefined opcodes never hit, so they also never move the line or trigger messages.
  always_comb begin
    op_known = (op_q >= OP_READ) && (op_q <= OP_RWIM);
    result   = RES_NOHIT;
    mesi_upd = mesi_q;
    if (op_known && match_q) begin
      case (mesi_q)
        MESI_M:         result = RES_HITM;
        MESI_S, MESI_E: result = RES_HIT;
        default:        result = RES_NOHIT;
      endcase
      case (op_q)
        OP_READ:  if (mesi_q != MESI_I) mesi_upd = MESI_S;
        OP_RWIM:  mesi_upd = MESI_I;
        OP_INV:   if (mesi_q == MESI_S) mesi_upd = MESI_I;
        OP_WRITE: mesi_upd = mesi_q;
        default:  mesi_upd = mesi_q;
      endcase
    end
  end

  always_comb begin
    state_nxt         = state;
    bus.snoop_valid   = 1'b0;
    bus.snoop_result  = RES_NOHIT;
    bus.wb_valid      = 1'b0;
    bus.wb_addr       = '0;
    bus.l1_msg_valid  = 1'b0;
    bus.l1_msg        = 3'd0;
    bus.l1_msg_addr   = '0;
    case (state)
      S_IDLE:   if (bus.bus_valid) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_RESPOND;
      S_RESPOND: begin
        bus.snoop_valid  = 1'b1;
        bus.snoop_result = result;
        if (result == RES_HITM && (op_q == OP_READ || op_q == OP_RWIM))
          state_nxt = S_GETL1;
        else
          state_nxt = S_UPDATE;
      end
      S_GETL1: begin
        bus.l1_msg_valid = 1'b1;
        bus.l1_msg       = MSG_GETLINE;
        bus.l1_msg_addr  = line_addr;
        state_nxt        = S_WBACK;
      end
      S_WBACK: begin
        bus.wb_valid = 1'b1;
        bus.wb_addr  = line_addr;
        if (bus.wb_ready) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        if (mesi_q != MESI_I && mesi_upd == MESI_I) begin
          bus.l1_msg_valid = 1'b1;
          bus.l1_msg       = MSG_INVLINE;
          bus.l1_msg_addr  = line_addr;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= 3'd0;
      line_q      <= '0;
      match_q     <= 1'b0;
      mesi_q      <= MESI_I;
      snoop_count <= 16'd0;
      hitm_count  <= 16'd0;
      for (int i = 0; i < LINES; i++) begin
        tag_arr[i]  <= '0;
        mesi_arr[i] <= MESI_I;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= bus.bus_op;
        line_q <= bus.bus_addr[ADDR_W-1:OFFSET_W];
        if (snoop_count != 16'hFFFF) snoop_count <= snoop_count + 16'd1;
      end
      if (fill_go) begin
        tag_arr[fill_idx]  <= fill_tag;
        mesi_arr[fill_idx] <= bus.fill_state;
      end
      if (state == S_LOOKUP) begin
        match_q <= (tag_arr[idx_q] == tag_q);
        mesi_q  <= mesi_arr[idx_q];
      end
      if (state == S_RESPOND && result == RES_HITM && hitm_count != 16'hFFFF)
        hitm_count <= hitm_count + 16'd1;
      if (state == S_UPDATE && match_q)
        mesi_arr[idx_q] <= mesi_upd;
    end
  end
endmodule

// File: tb/tb_llc_snoop_responder.sv
// Self-checking bench for llc_snoop_responder: directed MESI scenarios plus random traffic
// checked against a per-line MESI table model.
module tb_llc_snoop_responder;
  logic        clock;
  logic        reset;
  logic [15:0] snoop_count;
  logic [15:0] hitm_count;

  llc_snoop_responder_if #(.ADDR_W(32)) bif ();

  llc_snoop_responder dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bif),
    .snoop_count (snoop_count),
    .hitm_count  (hitm_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_mesi [16];
  logic [21:0] m_tag  [16];
  int          m_snoops;
  int          m_hitms;

  function automatic logic [1:0] exp_result(input logic [2:0] op, input logic [31:0] addr);
    int idx;
    idx = int'(addr[9:6]);
    if (op < 3'd1 || op > 3'd4) return 2'd0;
    if (m_tag[idx] != addr[31:10] || m_mesi[idx] == 2'd0) return 2'd0;
    return (m_mesi[idx] == 2'd3) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] next_mesi(input logic [2:0] op, input logic [1:0] cur);
    if (cur == 2'd0) return 2'd0;
    case (op)
      3'd1: return 2'd1;
      3'd4: return 2'd0;
      3'd3: return (cur == 2'd1) ? 2'd0 : cur;
      default: return cur;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_mesi[i] = 2'd0;
      m_tag[i]  = 22'd0;
    end
    m_snoops = 0;
    m_hitms  = 0;
  endtask

  task automatic model_snoop(input logic [2:0] op, input logic [31:0] addr);
    int idx;
    idx = int'(addr[9:6]);
    if (exp_result(op, addr) == 2'd2) m_hitms++;
    m_snoops++;
    if (m_tag[idx] == addr[31:10]) m_mesi[idx] = next_mesi(op, m_mesi[idx]);
  endtask

  task automatic idle_inputs();
    bif.bus_valid  = 1'b0;
    bif.bus_op     = 3'd0;
    bif.bus_addr   = 32'd0;
    bif.wb_ready   = 1'b0;
    bif.fill_valid = 1'b0;
    bif.fill_addr  = 32'd0;
    bif.fill_state = 2'd0;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [1:0] st);
    @(negedge clock);
    checks++;
    if (bif.fill_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready got %b want 1", bif.fill_ready);
    end
    bif.fill_valid = 1'b1;
    bif.fill_addr  = addr;
    bif.fill_state = st;
    @(negedge clock);
    bif.fill_valid = 1'b0;
    m_tag[addr[9:6]]  = addr[31:10];
    m_mesi[addr[9:6]] = st;
  endtask

  task automatic snoop(input logic [2:0] op, input logic [31:0] addr, input int wb_wait);
    logic [1:0]  er;
    logic [31:0] la;
    logic [1:0]  old_st;
    logic        wbk;
    int          wb_seen;
    int          cyc;
    logic [34:0] got_q[$];
    logic [34:0] exp_q[$];
    la  = {addr[31:6], 6'b0};
    er  = exp_result(op, addr);
    wbk = (er == 2'd2) && (op == 3'd1 || op == 3'd4);
    old_st = (m_tag[addr[9:6]] == addr[31:10]) ? m_mesi[addr[9:6]] : 2'd0;
    if (wbk) exp_q.push_back({3'd1, la});
    if (old_st != 2'd0 && next_mesi(op, old_st) == 2'd0) exp_q.push_back({3'd3, la});

    @(negedge clock);
    checks++;
    if (bif.bus_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_ready got %b want 1", bif.bus_ready);
    end
    bif.bus_valid = 1'b1;
    bif.bus_op    = op;
    bif.bus_addr  = addr;
    @(negedge clock);
    bif.bus_valid = 1'b0;
    checks++;
    if (bif.snoop_valid !== 1'b0) begin
      errors++;
      $display("FAIL snoop_early got %b want 0", bif.snoop_valid);
    end
    @(negedge clock);
    checks++;
    if (bif.snoop_valid !== 1'b1) begin
      errors++;
      $display("FAIL snoop_latency got %b want 1", bif.snoop_valid);
    end
    checks++;
    if (bif.snoop_result !== er) begin
      errors++;
      $display("FAIL result op=%0d addr=%h got %0d want %0d", op, addr, bif.snoop_result, er);
    end

    wb_seen = 0;
    cyc = 0;
    while (bif.bus_ready !== 1'b1 && cyc < 40) begin
      if (bif.l1_msg_valid === 1'b1) got_q.push_back({bif.l1_msg, bif.l1_msg_addr});
      if (bif.wb_valid === 1'b1) begin
        wb_seen++;
        checks++;
        if (bif.wb_addr !== la) begin
          errors++;
          $display("FAIL wb_addr got %h want %h", bif.wb_addr, la);
        end
        bif.wb_ready = (wb_seen > wb_wait);
      end else begin
        bif.wb_ready = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bif.wb_ready = 1'b0;

    checks++;
    if (cyc >= 40) begin
      errors++;
      $display("FAIL op_timeout cycles %0d limit 40", cyc);
    end
    checks++;
    if (wb_seen != (wbk ? wb_wait + 1 : 0)) begin
      errors++;
      $display("FAIL wb_cycles got %0d want %0d", wb_seen, wbk ? wb_wait + 1 : 0);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL l1_msg_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL l1_msg got %h want %h", got_q[i], exp_q[i]);
        end
      end
    end

    model_snoop(op, addr);
    checks++;
    if (snoop_count !== 16'(m_snoops) || hitm_count !== 16'(m_hitms)) begin
      errors++;
      $display("FAIL counters got %0d/%0d want %0d/%0d", snoop_count, hitm_count, m_snoops, m_hitms);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++;
    if (bif.bus_ready !== 1'b1 || bif.fill_ready !== 1'b1 || bif.snoop_valid !== 1'b0 ||
        bif.wb_valid !== 1'b0 || bif.l1_msg_valid !== 1'b0 || snoop_count !== 16'd0 ||
        hitm_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state rdy=%b frdy=%b sv=%b wb=%b l1=%b sc=%0d hc=%0d want 1 1 0 0 0 0 0",
               bif.bus_ready, bif.fill_ready, bif.snoop_valid, bif.wb_valid,
               bif.l1_msg_valid, snoop_count, hitm_count);
    end
    snoop(3'd1, 32'h0000_1040, 0);
  endtask

  task automatic test_hitm_writeback();
    fill(32'h0000_1040, 2'd3);
    snoop(3'd1, 32'h0000_1040, 3);
    snoop(3'd1, 32'h0000_1040, 0);
    checks++;
    if (hitm_count !== 16'd1) begin
      errors++;
      $display("FAIL hitm_count got %0d want 1", hitm_count);
    end
  endtask

  task automatic test_rwim();
    fill(32'h0000_2080, 2'd2);
    snoop(3'd4, 32'h0000_2090, 0);
    snoop(3'd1, 32'h0000_2080, 0);
  endtask

  task automatic test_tag_mismatch();
    fill(32'h0000_1040, 2'd1);
    snoop(3'd1, 32'h0000_5040, 0);
    snoop(3'd1, 32'h0000_1040, 0);
  endtask

  task automatic test_invalidate();
    fill(32'h0000_1040, 2'd1);
    snoop(3'd3, 32'h0000_1040, 0);
    snoop(3'd1, 32'h0000_1040, 0);
    fill(32'h0000_2080, 2'd3);
    snoop(3'd3, 32'h0000_2080, 0);
    snoop(3'd2, 32'h0000_2080, 0);
    snoop(3'd6, 32'h0000_2080, 0);
    snoop(3'd1, 32'h0000_2080, 1);
  endtask

  task automatic test_bus_over_fill();
    logic [1:0] er;
    logic       seen;
    int         cyc;
    er   = exp_result(3'd1, 32'h0000_6000);
    seen = 1'b0;
    @(negedge clock);
    bif.bus_valid  = 1'b1;
    bif.bus_op     = 3'd1;
    bif.bus_addr   = 32'h0000_6000;
    bif.fill_valid = 1'b1;
    bif.fill_addr  = 32'h0000_6000;
    bif.fill_state = 2'd2;
    #1;
    checks++;
    if (bif.fill_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_stall got %b want 0", bif.fill_ready);
    end
    @(negedge clock);
    bif.bus_valid = 1'b0;
    cyc = 0;
    while (bif.fill_ready !== 1'b1 && cyc < 20) begin
      if (bif.snoop_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bif.snoop_result !== er) begin
          errors++;
          $display("FAIL concurrent_result got %0d want %0d", bif.snoop_result, er);
        end
      end
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!seen || cyc >= 20) begin
      errors++;
      $display("FAIL concurrent_flow seen=%b cycles=%0d want 1 and <20", seen, cyc);
    end
    @(negedge clock);
    bif.fill_valid = 1'b0;
    model_snoop(3'd1, 32'h0000_6000);
    m_tag[0]  = 22'h000018;
    m_mesi[0] = 2'd2;
    checks++;
    if (snoop_count !== 16'(m_snoops)) begin
      errors++;
      $display("FAIL concurrent_count got %0d want %0d", snoop_count, m_snoops);
    end
    snoop(3'd1, 32'h0000_6000, 0);
  endtask

  task automatic test_reset_in_wback();
    int cyc;
    fill(32'h0000_3100, 2'd3);
    @(negedge clock);
    bif.bus_valid = 1'b1;
    bif.bus_op    = 3'd1;
    bif.bus_addr  = 32'h0000_3100;
    @(negedge clock);
    bif.bus_valid = 1'b0;
    cyc = 0;
    while (bif.wb_valid !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (bif.wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL wback_reach got %b want 1", bif.wb_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bif.wb_valid !== 1'b0 || bif.l1_msg_valid !== 1'b0 || bif.snoop_valid !== 1'b0 ||
        bif.bus_ready !== 1'b1 || snoop_count !== 16'd0 || hitm_count !== 16'd0) begin
      errors++;
      $display("FAIL abort wb=%b l1=%b sv=%b rdy=%b sc=%0d hc=%0d want 0 0 0 1 0 0",
               bif.wb_valid, bif.l1_msg_valid, bif.snoop_valid, bif.bus_ready,
               snoop_count, hitm_count);
    end
    reset = 1'b0;
    model_clear();
    snoop(3'd1, 32'h0000_3100, 0);
    snoop(3'd1, 32'h0000_6000, 0);
  endtask

  task automatic test_random();
    logic [21:0] tags [3];
    logic [31:0] a;
    tags[0] = 22'h000004;
    tags[1] = 22'h000015;
    tags[2] = 22'h0002A9;
    for (int n = 0; n < 200; n++) begin
      a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 3) == 0)
        fill(a, 2'($urandom_range(0, 3)));
      else
        snoop(3'($urandom_range(0, 7)), a, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_hitm_writeback();
    test_rwim();
    test_tag_mismatch();
    test_invalidate();
    test_bus_over_fill();
    test_reset_in_wback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
